// File: rtl/pll_seq_pkg.sv
// Shared state encoding and widths for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned RETRY_W = 4;

    typedef enum logic [STATE_W-1:0] {
        RST_HOLD  = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with a parameterised reset value and synchronous active-low reset.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/power-down sequencer: qualifies LOCK, retries on timeout, releases system reset.
// Optional PLL_LOSS_COUNT_EN adds a saturating lock-loss counter output (loss_cnt).
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 64,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRIES  = 7
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               lock_i,
    output logic               pll_reset,
    output logic               pll_pwd,
    output logic               sys_rst_n,
    output logic               pll_ok,
    output logic               fault,
    output logic [RETRY_W-1:0] retries,
    output logic [STATE_W-1:0] state_o
`ifdef PLL_LOSS_COUNT_EN
    ,
    output logic [7:0]         loss_cnt
`endif
);

    localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t               RST_LAST     = cnt_t'(RST_CYCLES - 1);
    localparam cnt_t               TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t               STABLE_LAST  = cnt_t'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES);

    logic               lock_s;
    state_t             state;
    state_t             state_next;
    cnt_t               cnt;
    cnt_t               cnt_next;
    logic [RETRY_W-1:0] retries_next;

    sync2 #(
        .RESET_VAL(1'b0)
    ) u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (lock_i),
        .q      (lock_s)
    );

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + cnt_t'(1);
        retries_next = retries;
        case (state)
            RST_HOLD: begin
                if (cnt == RST_LAST) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock seen in the timeout cycle still wins over a retry.
                if (lock_s) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_next = '0;
                    if (retries == RETRY_LAST) begin
                        state_next = FAULT;
                    end else begin
                        state_next   = RST_HOLD;
                        retries_next = retries + RETRY_W'(1);
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                cnt_next = '0;
                if (!lock_s) begin
                    state_next = RST_HOLD;
                end
            end
            FAULT: begin
                cnt_next = '0;
            end
            default: begin
                state_next = RST_HOLD;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= RST_HOLD;
            cnt       <= '0;
            retries   <= '0;
            pll_reset <= 1'b1;
            pll_pwd   <= 1'b0;
            sys_rst_n <= 1'b0;
            pll_ok    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            retries   <= retries_next;
            pll_reset <= (state_next == RST_HOLD) || (state_next == FAULT);
            pll_pwd   <= (state_next == FAULT);
            fault     <= (state_next == FAULT);
            pll_ok    <= (state_next == RUN);
            sys_rst_n <= (state_next == RUN);
        end
    end

    assign state_o = state;

`ifdef PLL_LOSS_COUNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            loss_cnt <= '0;
        end else if ((state == RUN) && (state_next == RST_HOLD) && (loss_cnt != '1)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed spec scenarios plus randomized lock/reset traffic.
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 16;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRIES  = 2;

    localparam int S_RST    = 0;
    localparam int S_WAIT   = 1;
    localparam int S_STABLE = 2;
    localparam int S_RUN    = 3;
    localparam int S_FAULT  = 4;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       lock_i = 1'b0;
    logic       pll_reset;
    logic       pll_pwd;
    logic       sys_rst_n;
    logic       pll_ok;
    logic       fault;
    logic [3:0] retries;
    logic [2:0] state_o;
`ifdef PLL_LOSS_COUNT_EN
    logic [7:0] loss_cnt;
`endif

    pll_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
`ifdef PLL_LOSS_COUNT_EN
        .loss_cnt  (loss_cnt),
`endif
        .clk       (clk),
        .resetn    (resetn),
        .lock_i    (lock_i),
        .pll_reset (pll_reset),
        .pll_pwd   (pll_pwd),
        .sys_rst_n (sys_rst_n),
        .pll_ok    (pll_ok),
        .fault     (fault),
        .retries   (retries),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: phase plus the cycle index at which that phase was entered.
    int   m_state   = S_RST;
    int   m_since   = 0;
    int   m_cyc     = 0;
    int   m_retries = 0;
`ifdef PLL_LOSS_COUNT_EN
    int   m_loss    = 0;
`endif
    logic lq[$]     = '{1'b0, 1'b0};

    task automatic enter(input int s);
        m_state = s;
        m_since = m_cyc;
    endtask

    task automatic model_step(input logic r, input logic l);
        int   cur;
        int   occ;
        logic ls;
        cur   = m_cyc;
        m_cyc = cur + 1;
        if (!r) begin
            enter(S_RST);
            m_retries = 0;
`ifdef PLL_LOSS_COUNT_EN
            m_loss = 0;
`endif
            lq = '{1'b0, 1'b0};
        end else begin
            ls = lq[1];
            lq.push_front(l);
            void'(lq.pop_back());
            occ = cur - m_since + 1;
            case (m_state)
                S_RST:    if (occ == RST_CYCLES) enter(S_WAIT);
                S_WAIT: begin
                    if (ls) enter(S_STABLE);
                    else if (occ == LOCK_TIMEOUT) begin
                        if (m_retries == MAX_RETRIES) enter(S_FAULT);
                        else begin
                            m_retries++;
                            enter(S_RST);
                        end
                    end
                end
                S_STABLE: begin
                    if (!ls) enter(S_WAIT);
                    else if (occ == LOCK_STABLE) enter(S_RUN);
                end
                S_RUN: begin
                    if (!ls) begin
                        enter(S_RST);
`ifdef PLL_LOSS_COUNT_EN
                        if (m_loss < 255) m_loss++;
`endif
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check("state",     32'(state_o),   m_state);
        check("pll_reset", 32'(pll_reset), (m_state == S_RST || m_state == S_FAULT) ? 1 : 0);
        check("pll_pwd",   32'(pll_pwd),   (m_state == S_FAULT) ? 1 : 0);
        check("fault",     32'(fault),     (m_state == S_FAULT) ? 1 : 0);
        check("pll_ok",    32'(pll_ok),    (m_state == S_RUN) ? 1 : 0);
        check("sys_rst_n", 32'(sys_rst_n), (m_state == S_RUN) ? 1 : 0);
        check("retries",   32'(retries),   m_retries);
`ifdef PLL_LOSS_COUNT_EN
        check("loss_cnt",  32'(loss_cnt),  m_loss);
`endif
    endtask

    task automatic tick();
        logic r;
        logic l;
        r = resetn;
        l = lock_i;
        @(posedge clk);
        #1;
        model_step(r, l);
        compare_all();
    endtask

    // Starting from the visible first RST_HOLD cycle (cycle 0) with lock held high.
    task automatic nominal(input string tag);
        lock_i = 1'b1;
        resetn = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            check({tag, "_pll_reset"}, 32'(pll_reset), (c < 4) ? 1 : 0);
            check({tag, "_pll_ok"},    32'(pll_ok),    (c >= 13) ? 1 : 0);
            check({tag, "_sys_rst_n"}, 32'(sys_rst_n), (c >= 13) ? 1 : 0);
        end
        check({tag, "_retries"}, 32'(retries), 0);
    endtask

    initial begin
        // Reset values, then nominal lock
        resetn = 1'b0;
        lock_i = 1'b1;
        repeat (3) tick();
        check("rst_state",     32'(state_o),   S_RST);
        check("rst_pll_reset", 32'(pll_reset), 1);
        check("rst_pll_pwd",   32'(pll_pwd),   0);
        check("rst_sys_rst_n", 32'(sys_rst_n), 0);
        check("rst_pll_ok",    32'(pll_ok),    0);
        check("rst_fault",     32'(fault),     0);
        check("rst_retries",   32'(retries),   0);
        nominal("nom");

        // One-cycle lock drop while in RUN
        lock_i = 1'b0;
        tick();
        check("loss_e1_sys_rst_n", 32'(sys_rst_n), 1);
        lock_i = 1'b1;
        tick();
        check("loss_e2_sys_rst_n", 32'(sys_rst_n), 1);
        tick();
        check("loss_e3_state",     32'(state_o),   S_RST);
        check("loss_e3_sys_rst_n", 32'(sys_rst_n), 0);
        check("loss_e3_pll_ok",    32'(pll_ok),    0);
        nominal("relock");
`ifdef PLL_LOSS_COUNT_EN
        check("loss_cnt_one", 32'(loss_cnt), 1);
`endif

        // Glitch while STABLE at cnt=5: lock_i low during cycle 8 makes lock_s low in cycle 10
        resetn = 1'b0;
        lock_i = 1'b1;
        tick();
        resetn = 1'b1;
        for (int c = 0; c <= 21; c++) begin
            lock_i = (c == 8) ? 1'b0 : 1'b1;
            tick();
            check("glitch_pll_ok", 32'(pll_ok), (c + 1 >= 20) ? 1 : 0);
            if (c + 1 == 10) check("glitch_c10_state", 32'(state_o), S_STABLE);
            if (c + 1 == 11) check("glitch_c11_state", 32'(state_o), S_WAIT);
        end
        check("glitch_retries", 32'(retries), 0);

        // No lock: three 20-cycle attempts then FAULT for 1000 cycles
        resetn = 1'b0;
        lock_i = 1'b0;
        tick();
        resetn = 1'b1;
        for (int c = 1; c <= 1060; c++) begin
            tick();
            check("nolock_retries",   32'(retries),   (c < 20) ? 0 : ((c < 40) ? 1 : 2));
            check("nolock_fault",     32'(fault),     (c >= 60) ? 1 : 0);
            check("nolock_pll_pwd",   32'(pll_pwd),   (c >= 60) ? 1 : 0);
            check("nolock_pll_reset", 32'(pll_reset), (c >= 60 || (c % 20) < 4) ? 1 : 0);
            check("nolock_is_fault",  (state_o == 3'd4) ? 32'd1 : 32'd0, (c >= 60) ? 1 : 0);
        end

        // Reset out of FAULT
        resetn = 1'b0;
        lock_i = 1'b1;
        tick();
        check("unfault_fault",     32'(fault),     0);
        check("unfault_pll_pwd",   32'(pll_pwd),   0);
        check("unfault_pll_reset", 32'(pll_reset), 1);
        nominal("after_fault");

`ifdef PLL_LOSS_COUNT_EN
        for (int k = 0; k < 260; k++) begin
            int n;
            lock_i = 1'b0;
            tick();
            lock_i = 1'b1;
            tick();
            tick();
            n = 0;
            while (!pll_ok && n < 40) begin
                tick();
                n++;
            end
            if (n >= 40) check("relock_bound", 32'(n), 39);
        end
        check("loss_cnt_sat", 32'(loss_cnt), 255);
`endif

        // Randomized lock segments with occasional resets
        for (int seg = 0; seg < 200; seg++) begin
            int roll;
            int len;
            roll = int'($urandom_range(0, 99));
            if (roll < 4) begin
                resetn = 1'b0;
                lock_i = 1'($urandom_range(0, 1));
                len    = int'($urandom_range(1, 2));
            end else begin
                resetn = 1'b1;
                lock_i = (roll < 70) ? 1'b1 : 1'b0;
                len    = lock_i ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 80));
            end
            repeat (len) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Control-side counterpart of the vendor PLL wrappers such as the 50→126 MHz console PLL.
- Drives the PLL RESET and PLLPWD pins and consumes its asynchronous LOCK.
- Qualifies LOCK, retries PLL lock with a timeout, and releases the downstream system reset only after lock has been stable.
- Runs on the board reference clock (the PLL input clock), never on a PLL output.

Parameters:
- RST_CYCLES, 64: clocks PLL reset is held per attempt.
- LOCK_TIMEOUT, 50000: clocks to wait for lock before retry (1 ms at 50 MHz).
- LOCK_STABLE, 1024: consecutive clocks of synchronized lock required before release.
- MAX_RETRIES, 7: retries after the first attempt before FAULT (≤15).

Ports:
- clk  in  1  board reference clock (PLL clkin)
- resetn  in  1  synchronous active-low reset
- lock_i  in  1  PLL LOCK, asynchronous
- pll_reset  out  1  to PLL RESET, active high
- pll_pwd  out  1  to PLL PLLPWD, active high
- sys_rst_n  out  1  system reset, active low; consumers resynchronize it into PLL clock domains
- pll_ok  out  1  PLL locked and qualified
- fault  out  1  retries exhausted
- retries  out  4  timeout retries taken
- state_o  out  3  current state encoding, for debug display

Behaviour:
- Reset is synchronous and active-low on resetn, sampled at posedge clk.
- While resetn=0: state=RST_HOLD, cnt=0, pll_reset=1, pll_pwd=0, sys_rst_n=0, pll_ok=0, fault=0, retries=0, sync flops=0.
- lock_i passes through a 2-flop synchronizer to give lock_s (2-cycle latency). All outputs are registered.
- Counter width is $clog2 of the largest of the count parameters.
- RST_HOLD (0):
  - pll_reset=1.
  - Lasts exactly RST_CYCLES clocks, then → WAIT_LOCK with cnt=0.
- WAIT_LOCK (1):
  - pll_reset=0.
  - If lock_s=1 → STABLE, cnt=0.
  - Else if cnt=LOCK_TIMEOUT-1: if retries=MAX_RETRIES → FAULT; otherwise retries+1 → RST_HOLD.
  - lock_s=1 takes priority over timeout in the same cycle.
- STABLE (2):
  - If lock_s=0 → WAIT_LOCK with cnt=0; the timeout restarts and retries is unchanged.
  - Lasts exactly LOCK_STABLE clocks with lock_s=1, then → RUN.
- RUN (3):
  - pll_ok=1 and sys_rst_n=1, both rising on the edge that enters RUN.
  - If lock_s=0 → RST_HOLD; pll_ok=0 and sys_rst_n=0 on that same edge.
  - Lock loss does not increment retries.
- FAULT (4):
  - pll_reset=1, pll_pwd=1, fault=1, sys_rst_n=0, pll_ok=0.
  - Terminal state; only resetn exits it.
- resetn=0 in any state returns to the reset values on the next edge. sys_rst_n falls on that edge.
- retries saturates by construction, since FAULT is entered instead of incrementing past MAX_RETRIES.
- pll_pwd is 0 in every state except FAULT.

Optional Feature:
- Macro: PLL_LOSS_COUNT_EN.
- When defined:
  - Adds output loss_cnt[7:0]: a saturating count of RUN→RST_HOLD lock-loss transitions.
  - Reset value 0; holds at 255.
- When undefined:
  - The port does not exist and no counter logic is built.
  - All other behaviour is identical.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum (RST_HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4) and its 3-bit width constant;
  - the 4-bit retries width constant.
- One sub-module: sync2 (2-flop synchronizer, reset value parameter), reused for lock_i.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=16, LOCK_STABLE=8, MAX_RETRIES=2; cycle 0 = first cycle with resetn=1):
- lock_i held 1 → pll_reset low from cycle 4; pll_ok=sys_rst_n=1 from cycle 13; retries=0.
- lock_i held 0 → three attempts of 20 cycles each; retries reads 1 then 2; FAULT from cycle 60 with fault=1, pll_pwd=1, pll_reset=1; remains there for 1000 cycles.
- In RUN, pull lock_i low for 1 cycle → state RST_HOLD and sys_rst_n=0 three edges later (2 sync + 1); relock follows the nominal sequence; retries unchanged; loss_cnt=1 if PLL_LOSS_COUNT_EN.
- In STABLE at cnt=5, glitch lock_i low → returns to WAIT_LOCK; pll_ok high only after 8 further continuous stable clocks.
- resetn low for 1 cycle while in FAULT → fault=0, pll_pwd=0, pll_reset=1 next edge; nominal lock sequence follows.
- PLL_LOSS_COUNT_EN: 260 forced lock losses → loss_cnt saturates at 255.
